// File: rtl/rpn_calc_pkg.sv
// Shared definitions for the RPN calculator: token codes, sequencer states and ALU ops.
package rpn_calc_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_EQ  = 4'hE;
  localparam logic [3:0] OP_CLR = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PUSH_N = 4'd1,
    S_POP_B  = 4'd2,
    S_POP_A  = 4'd3,
    S_EXEC   = 4'd4,
    S_PUSH_Y = 4'd5,
    S_FINISH = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8,
    S_CLR    = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } alu_op_t;

  function automatic alu_op_t op_to_alu(input logic [3:0] code);
    alu_op_t op;
    case (code)
      OP_SUB:  op = ALU_SUB;
      OP_MUL:  op = ALU_MUL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/operand_stack.sv
// Operand stack: DEPTH x WIDTH register array with one push or one pop per cycle,
// flush (optionally combined with a push to restart at depth 1) and a registered top.
module operand_stack
  import rpn_calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_top;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_below_idx;
  logic             w_full;
  logic             w_empty;

  // DEPTH is a power of two, so modulo-DEPTH index arithmetic stays exact at full depth
  assign w_wr_idx    = r_cnt[AW-1:0];
  assign w_below_idx = w_wr_idx - AW'(2);
  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_empty     = (r_cnt == {CW{1'b0}});

  // Array, pointer and cached top update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_top <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      if (i_push) begin
        r_mem[{AW{1'b0}}] <= i_data;
        r_cnt             <= CW'(1);
        r_top             <= i_data;
      end else begin
        r_cnt <= '0;
        r_top <= '0;
      end
    end else if (i_push && !w_full) begin
      r_mem[w_wr_idx] <= i_data;
      r_cnt           <= r_cnt + CW'(1);
      r_top           <= i_data;
    end else if (i_pop && !w_empty) begin
      r_cnt <= r_cnt - CW'(1);
      r_top <= (r_cnt >= CW'(2)) ? r_mem[w_below_idx] : '0;
    end else begin
      r_cnt <= r_cnt;
      r_top <= r_top;
    end
  end

  assign o_top   = r_top;
  assign o_depth = r_cnt;

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN token sequencer: FSM and ALU driving operand_stack.
// Optional multiplier enabled by defining RPN_SEQ_MUL_EN; otherwise 4'hC is illegal.
module rpn_stack_sequencer
  import rpn_calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tok_valid,
  output logic                       tok_ready,
  input  logic                       tok_is_num,
  input  logic [WIDTH-1:0]           tok_num,
  input  logic [3:0]                 tok_op,
  output logic [WIDTH-1:0]           result,
  output logic                       result_valid,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       err_underflow,
  output logic                       err_overflow,
  output logic                       err_illegal
);

  localparam int CW = $clog2(DEPTH + 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_rdy;
  logic             r_busy;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  alu_op_t          r_alu_op;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_err_uf;
  logic             r_err_of;
  logic             r_err_il;

  logic             w_fire;
  logic             w_tok_arith;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_set_uf;
  logic             w_set_of;
  logic             w_set_il;
  logic             w_clr_err;
  logic [WIDTH-1:0] w_push_data;
  logic [WIDTH-1:0] w_alu_y;
  logic [WIDTH-1:0] w_top;
  logic [CW-1:0]    w_depth;

  assign w_fire = tok_valid & r_rdy;

  operand_stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_data),
    .o_top   (w_top),
    .o_depth (w_depth)
  );

  // Which operator codes are executable arithmetic in this build
  always_comb begin
    w_tok_arith = 1'b0;
    case (tok_op)
      OP_ADD, OP_SUB: w_tok_arith = 1'b1;
`ifdef RPN_SEQ_MUL_EN
      OP_MUL:         w_tok_arith = 1'b1;
`endif
      default:        w_tok_arith = 1'b0;
    endcase
  end

  // ALU: deeper operand (a) is always on the left
  always_comb begin
    w_alu_y = '0;
    case (r_alu_op)
      ALU_ADD: w_alu_y = r_a + r_b;
      ALU_SUB: w_alu_y = r_a - r_b;
`ifdef RPN_SEQ_MUL_EN
      ALU_MUL: w_alu_y = r_a * r_b;
`endif
      default: w_alu_y = r_a + r_b;
    endcase
  end

  // Next-state and stack control
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_set_uf    = 1'b0;
    w_set_of    = 1'b0;
    w_set_il    = 1'b0;
    w_clr_err   = 1'b0;
    w_push_data = r_num;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          if (tok_is_num) begin
            if (w_depth < CW'(DEPTH)) begin
              w_state_nxt = S_PUSH_N;
            end else begin
              w_set_of    = 1'b1;
              w_state_nxt = S_ERROR;
            end
          end else if (w_tok_arith) begin
            if (w_depth >= CW'(2)) begin
              w_state_nxt = S_POP_B;
            end else begin
              w_set_uf    = 1'b1;
              w_state_nxt = S_ERROR;
            end
          end else if (tok_op == OP_EQ) begin
            if (w_depth == CW'(1)) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_set_uf    = 1'b1;
              w_state_nxt = S_ERROR;
            end
          end else if (tok_op == OP_CLR) begin
            w_state_nxt = S_CLR;
          end else begin
            w_set_il    = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PUSH_N: begin
        w_push      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_POP_B: begin
        w_pop       = 1'b1;
        w_state_nxt = S_POP_A;
      end
      S_POP_A: begin
        w_pop       = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC:   w_state_nxt = S_PUSH_Y;
      S_PUSH_Y: begin
        w_push      = 1'b1;
        w_push_data = r_y;
        w_state_nxt = S_IDLE;
      end
      S_FINISH: w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_fire && tok_is_num) begin
          w_flush     = 1'b1;
          w_push      = 1'b1;
          w_push_data = tok_num;
          w_state_nxt = S_IDLE;
        end else if (w_fire && tok_op == OP_CLR) begin
          w_state_nxt = S_CLR;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERROR: begin
        if (w_fire && !tok_is_num && tok_op == OP_CLR) begin
          w_state_nxt = S_CLR;
        end else begin
          w_state_nxt = S_ERROR;
        end
      end
      S_CLR: begin
        w_flush     = 1'b1;
        w_clr_err   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; ready and busy are registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                 (w_state_nxt == S_ERROR);
      r_busy  <= (w_state_nxt == S_POP_B) || (w_state_nxt == S_POP_A) ||
                 (w_state_nxt == S_EXEC)  || (w_state_nxt == S_PUSH_Y);
    end
  end

  // Operand capture, ALU result and answer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_y            <= '0;
      r_alu_op       <= ALU_ADD;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_fire && tok_is_num) begin
        r_num <= tok_num;
      end
      if (w_fire && !tok_is_num) begin
        r_alu_op <= op_to_alu(tok_op);
      end
      if (r_state == S_POP_B) begin
        r_b <= w_top;
      end
      if (r_state == S_POP_A) begin
        r_a <= w_top;
      end
      if (r_state == S_EXEC) begin
        r_y <= w_alu_y;
      end
      if (r_state == S_FINISH) begin
        r_result <= w_top;
      end
      r_result_valid <= (r_state == S_FINISH);
    end
  end

  // Sticky error flags, cleared only by CLR or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
      r_err_il <= 1'b0;
    end else if (w_clr_err) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
      r_err_il <= 1'b0;
    end else begin
      r_err_uf <= r_err_uf | w_set_uf;
      r_err_of <= r_err_of | w_set_of;
      r_err_il <= r_err_il | w_set_il;
    end
  end

  assign tok_ready     = r_rdy;
  assign busy          = r_busy;
  assign result        = r_result;
  assign result_valid  = r_result_valid;
  assign top           = w_top;
  assign depth         = w_depth;
  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;
  assign err_illegal   = r_err_il;

endmodule
